// File: rtl/hft_msg_pkg.sv
// rtl/hft_msg_pkg.sv - shared message type codes, payload field layout and helpers
package hft_msg_pkg;

  localparam logic [1:0] MSG_ADD     = 2'b00;
  localparam logic [1:0] MSG_CANCEL  = 2'b01;
  localparam logic [1:0] MSG_EXEC    = 2'b10;
  localparam logic [1:0] MSG_ILLEGAL = 2'b11;

  // order_id sits at the top of the payload; price/size occupy the low 16 bits
  localparam int ORDER_ID_W = 16;
  localparam int PRICE_W    = 8;
  localparam int SIZE_W     = 8;
  localparam int SIZE_LSB   = 0;
  localparam int PRICE_LSB  = SIZE_LSB + SIZE_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } enc_state_e;

  // Clamp a 16-bit quantity into an 8-bit field
  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic is_sat8(input logic [15:0] v);
    return (v > 16'd255);
  endfunction

endpackage

// File: rtl/msg_sync_fifo.sv
// rtl/msg_sync_fifo.sv - synchronous FIFO with full/empty, any depth >= 1
module msg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap by compare
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset; only valid entries are ever read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/order_msg_encoder.sv
// rtl/order_msg_encoder.sv - order command encoder with FIFO and valid/ready message port (option: ORDER_MSG_ENCODER_STATS_EN)
module order_msg_encoder
  import hft_msg_pkg::*;
#(
  parameter int PAYLOAD_LEN = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_type,
  input  logic [15:0]              cmd_order_id,
  input  logic [15:0]              cmd_price,
  input  logic [15:0]              cmd_size,
  output logic                     msg_valid,
  input  logic                     msg_ready,
  output logic [1:0]               msg_type,
  output logic [PAYLOAD_LEN*8-1:0] msg_payload,
  output logic                     err_illegal,
  output logic                     err_sat
`ifdef ORDER_MSG_ENCODER_STATS_EN
  ,
  output logic [15:0]              stat_add,
  output logic [15:0]              stat_cancel,
  output logic [15:0]              stat_exec,
  output logic [15:0]              stat_drop
`endif
);

  localparam int PW    = PAYLOAD_LEN * 8;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  enc_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]     msg_type_q, msg_type_d;
  logic [PW-1:0]  msg_payload_q, msg_payload_d;
  logic           err_illegal_q, err_illegal_d;
  logic           err_sat_q, err_sat_d;

  logic           accept, push, pop;
  logic [PW-1:0]  enc_payload;
  logic           enc_sat;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PW+1:0]  fifo_rd;

  assign cmd_ready   = (count_q < CNT_W'(FIFO_DEPTH));
  assign accept      = cmd_valid && cmd_ready;
  assign push        = accept && (cmd_type != MSG_ILLEGAL);
  assign msg_valid   = (state_q == ST_VALID);
  assign pop         = msg_valid && msg_ready;
  assign msg_type    = msg_type_q;
  assign msg_payload = msg_payload_q;
  assign err_illegal = err_illegal_q;
  assign err_sat     = err_sat_q;

  // Pack the command; only fields the type actually uses can flag saturation
  always_comb begin
    enc_payload = '0;
    enc_sat     = 1'b0;
    enc_payload[PW-1 -: ORDER_ID_W] = cmd_order_id;
    case (cmd_type)
      MSG_ADD: begin
        enc_payload[PRICE_LSB +: PRICE_W] = sat8(cmd_price);
        enc_payload[SIZE_LSB +: SIZE_W]   = sat8(cmd_size);
        enc_sat = is_sat8(cmd_price) || is_sat8(cmd_size);
      end
      MSG_EXEC: begin
        enc_payload[SIZE_LSB +: SIZE_W] = sat8(cmd_size);
        enc_sat = is_sat8(cmd_size);
      end
      default: ;
    endcase
  end

  // Output register FSM: load directly when the path is free, otherwise queue
  always_comb begin
    state_d       = state_q;
    msg_type_d    = msg_type_q;
    msg_payload_d = msg_payload_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    err_sat_d     = push && enc_sat;
    err_illegal_d = accept && (cmd_type == MSG_ILLEGAL);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          msg_type_d    = cmd_type;
          msg_payload_d = enc_payload;
          state_d       = ST_VALID;
        end
      end
      ST_VALID: begin
        if (pop) begin
          if (!fifo_empty) begin
            {msg_type_d, msg_payload_d} = fifo_rd;
            fifo_pop  = 1'b1;
            fifo_push = push && !fifo_full;
          end else if (push) begin
            msg_type_d    = cmd_type;
            msg_payload_d = enc_payload;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fifo_push = push && !fifo_full;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, output register and error pulse flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      msg_type_q    <= '0;
      msg_payload_q <= '0;
      err_illegal_q <= 1'b0;
      err_sat_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      msg_type_q    <= msg_type_d;
      msg_payload_q <= msg_payload_d;
      err_illegal_q <= err_illegal_d;
      err_sat_q     <= err_sat_d;
    end
  end

  msg_sync_fifo #(
    .WIDTH(PW + 2),
    .DEPTH(FIFO_DEPTH - 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .wr_data({cmd_type, enc_payload}),
    .pop    (fifo_pop),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

`ifdef ORDER_MSG_ENCODER_STATS_EN
  logic [15:0] stat_add_q, stat_add_d;
  logic [15:0] stat_cancel_q, stat_cancel_d;
  logic [15:0] stat_exec_q, stat_exec_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  assign stat_add    = stat_add_q;
  assign stat_cancel = stat_cancel_q;
  assign stat_exec   = stat_exec_q;
  assign stat_drop   = stat_drop_q;

  // Wrapping counters of delivered messages by type and dropped commands
  always_comb begin
    stat_add_d    = stat_add_q;
    stat_cancel_d = stat_cancel_q;
    stat_exec_d   = stat_exec_q;
    stat_drop_d   = stat_drop_q;
    if (pop && msg_type_q == MSG_ADD)    stat_add_d    = stat_add_q + 16'd1;
    if (pop && msg_type_q == MSG_CANCEL) stat_cancel_d = stat_cancel_q + 16'd1;
    if (pop && msg_type_q == MSG_EXEC)   stat_exec_d   = stat_exec_q + 16'd1;
    if (err_illegal_d)                   stat_drop_d   = stat_drop_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_add_q    <= '0;
      stat_cancel_q <= '0;
      stat_exec_q   <= '0;
      stat_drop_q   <= '0;
    end else begin
      stat_add_q    <= stat_add_d;
      stat_cancel_q <= stat_cancel_d;
      stat_exec_q   <= stat_exec_d;
      stat_drop_q   <= stat_drop_d;
    end
  end
`endif

endmodule

// File: doc/order_msg_encoder.md
# order_msg_encoder

Transmit-side counterpart of the message parser. Accepts order events (add, cancel, execute) on a command handshake, encodes each into the 2-bit type plus packed payload format that the parser decodes, buffers them in a small FIFO, and presents them on a valid/ready message port. Sits between the strategy/order-management logic and the message link that feeds the parser side.

## Interface
- `PAYLOAD_LEN`, 4, payload width in bytes; legal range is ≥4.
- `FIFO_DEPTH`, 4, total message slots, including the output register; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted.
- `cmd_type` in 2: 00 ADD, 01 CANCEL, 10 EXEC, 11 illegal.
- `cmd_order_id` in 16: order identifier.
- `cmd_price` in 16: price; encoded to 8 bits.
- `cmd_size` in 16: size; encoded to 8 bits.
- `msg_valid` out 1: message present.
- `msg_ready` in 1: downstream accepts the message.
- `msg_type` out 2: message type.
- `msg_payload` out PAYLOAD_LEN*8: encoded payload.
- `err_illegal` out 1: one-cycle pulse when an illegal command is dropped.
- `err_sat` out 1: one-cycle pulse when price or size was saturated.

## Operation
- **Accept rule.** A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- **Payload encoding.** `order_id` goes to `payload[PAYLOAD_LEN*8-1 -:16]`. Bits between bit 16 and the order_id field are zero.
  - ADD: `[15:8]` = price8, `[7:0]` = size8.
  - CANCEL: `[15:0]` = 0.
  - EXEC: `[15:8]` = 0, `[7:0]` = size8.
- **Saturation.** price8 = `(price > 255) ? 8'hFF : price[7:0]`. size8 is derived the same way.
  - `err_sat` pulses on the accept cycle +1 if any field used by that type saturated.
  - Fields not used by the type (price for CANCEL/EXEC, size for CANCEL) never raise `err_sat`.
- **Illegal type.** An accepted `cmd_type` 11 is consumed: it is not enqueued and `cmd_ready` is unaffected. `err_illegal` pulses on the next cycle.
- **Output FSM.**
  - IDLE → VALID when the output register loads.
  - VALID → IDLE on a handshake when the FIFO is empty.
  - VALID → VALID on a handshake when the FIFO is non-empty; the next entry loads on the same edge.
- **Occupancy.** `count` covers the FIFO plus the output register. It increments on push, decrements on a `msg_valid && msg_ready` handshake, and is unchanged on simultaneous push and pop.
- **Ready rule.** `cmd_ready = (count < FIFO_DEPTH)`. It is registered-state only, with no combinational path from `msg_ready`. When full, a simultaneous pop does not raise ready in that cycle.
- **Ordering.** Messages are strictly FIFO; no reordering or merging.

## Timing
- **Reset values.** `cmd_ready`=1, `msg_valid`=0, `msg_type`=0, `msg_payload`=0, `err_illegal`=0, `err_sat`=0, `count`=0, FSM in IDLE, FIFO pointers at 0.
- **Latency.** A command accepted at edge N with the block empty gives `msg_valid`=1 after edge N (visible in cycle N+1).
- **Throughput.** One message per cycle sustained while `msg_ready`=1.
- **Backpressure.** While `msg_valid && !msg_ready`, `msg_type` and `msg_payload` hold stable. `msg_valid` never deasserts without a handshake.
- **Reset mid-operation.** Asserting `rst_n` low flushes all queued messages immediately; outputs return to reset values asynchronously.
- **Pointer wrap.** FIFO pointers wrap modulo the FIFO storage depth (`FIFO_DEPTH-1` slots plus the output register).

## Configuration
- `ORDER_MSG_ENCODER_STATS_EN` defined: adds output ports `stat_add`, `stat_cancel`, `stat_exec`, `stat_drop` (16 bits each, wrapping).
  - The first three increment on a message handshake of the matching type.
  - `stat_drop` increments on each illegal command.
  - All four reset to 0.
- Not defined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `hft_msg_pkg` holds:
  - msg type constants `MSG_ADD`=2'b00, `MSG_CANCEL`=2'b01, `MSG_EXEC`=2'b10.
  - payload field offsets and widths (order_id 16, price 8, size 8).
  - The parser side imports the same package.
- One sub-module, `msg_sync_fifo`: parameterised width and depth, synchronous FIFO with full/empty. The output register and FSM stay in the top level.

## Test plan
- **Single ADD.** Reset, then ADD id=0x1234 price=0x56 size=0x78 → next cycle `msg_valid`=1, `msg_type`=00, `payload`=0x12345678; handshake with `msg_ready`=1 → `msg_valid`=0.
- **CANCEL and EXEC.** CANCEL id=0xBEEF → payload 0xBEEF0000. EXEC id=0x0001 price=0x99 size=0x22 → payload 0x00010022, no `err_sat`.
- **Saturation.** ADD price=0x0123 size=0x0005 → payload low half 0xFF05, `err_sat` pulses one cycle. CANCEL price=0xFFFF → no `err_sat`.
- **Illegal type.** `cmd_type`=11 → `err_illegal` one-cycle pulse, nothing emitted, `count` unchanged.
- **Backpressure fill.** `msg_ready`=0, push 4 commands → `cmd_ready`=0 after the 4th, first payload held stable. Release `msg_ready` → the 4 messages emerge in order on consecutive cycles.
- **Reset flush.** 3 messages queued, pulse `rst_n` low → `msg_valid`=0 and `cmd_ready`=1 immediately. No stale message after release.
